alu_driver: RTL and testbench
=============================

Name: alu_driver

Overview:
Initiator side of the ALU operand/result interface.
- Receives byte-wide command frames from the pin-level input bus through a valid/ready handshake.
- Registers the frame's operands onto the ALU operand ports (o_s1, o_s2) and samples the ALU's combinational result one cycle later.
- Holds the result on a valid/ready output until it is consumed.
- Keeps an accumulator (last result) so frames can be chained.
- Sits between the top-level I/O pins and the ALU.

Parameters:
G_N_BIT, 8, ALU datapath width in bits; legal range 1..8. Operands are the low G_N_BIT bits of a frame byte.

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous reset, active high
i_byte  in  8  command/operand byte
i_byte_valid  in  1  i_byte is valid this cycle
o_byte_ready  out  1  driver accepts i_byte this cycle
o_s1  out  G_N_BIT  ALU operand 1, registered
o_s2  out  G_N_BIT  ALU operand 2, registered
i_res  in  G_N_BIT  ALU result, combinational from o_s1/o_s2
o_res  out  G_N_BIT  captured result, registered
o_res_valid  out  1  o_res is valid
i_res_ready  in  1  consumer takes o_res this cycle
o_busy  out  1  high in every state except S_HDR

Behaviour:
- Single clock domain. Reset is synchronous and active high.
- Reset (i_rst high at a clock edge):
  - state goes to S_HDR;
  - o_s1, o_s2, o_res and the accumulator all go to 0;
  - o_res_valid goes to 0.
  - Reset mid-frame or mid-output discards the frame and any pending result with no output.
- Byte transfer happens on a cycle with i_byte_valid=1 and o_byte_ready=1. o_byte_ready=1 only in S_HDR, S_A and S_B.
- Header byte:
  - bit1 CLR: set accumulator to 0; frame ends with no operands and no result.
  - bit0 CHAIN: s1 is the accumulator; the frame is header followed by B.
  - Otherwise the frame is header, A, B.
  - CLR overrides CHAIN. Bits 7..2 are ignored.
- FSM:
  - S_HDR, on transfer:
    - CLR: accumulator <= 0, stay in S_HDR.
    - CHAIN: o_s1 <= accumulator, go to S_B.
    - Else: go to S_A.
  - S_A, on transfer: o_s1 <= i_byte[G_N_BIT-1:0], go to S_B.
  - S_B, on transfer: o_s2 <= i_byte[G_N_BIT-1:0], go to S_EXEC.
  - S_EXEC (exactly one cycle): o_s1/o_s2 are stable; at the edge, o_res <= i_res and accumulator <= i_res; go to S_OUT.
  - S_OUT: o_res_valid=1. When i_res_ready=1, go to S_HDR (o_res_valid=0 next cycle). o_res holds until the next S_EXEC.
- Latency:
  - B byte accepted in cycle t: S_EXEC in t+1, o_res_valid=1 from t+2.
  - With i_res_ready held high, the next header can be accepted at t+3.
  - Non-chained frame: minimum 5 cycles per frame. Chained frame: minimum 4 cycles.
- Arithmetic/width: the driver does no arithmetic; i_res is taken as-is and wraps at G_N_BIT in the ALU. Unused upper operand-byte bits are dropped.
- Boundary conditions:
  - i_byte_valid held high through S_EXEC/S_OUT: no transfer; the byte is held off by o_byte_ready=0.
  - i_res_ready high before o_res_valid: no effect.
  - i_res_ready held low: stall indefinitely in S_OUT; o_res and o_res_valid stay stable.
  - Bubbles (i_byte_valid=0) between frame bytes: the FSM waits in its current state; no timeout.
  - CHAIN before any result: accumulator is 0 (reset or CLR value).
  - o_s1/o_s2 hold their last values between frames. The ALU output is only sampled in S_EXEC.

Decomposition:
- Shared package:
  - state enumeration (S_HDR, S_A, S_B, S_EXEC, S_OUT);
  - header bit-position constants C_HDR_CHAIN=0, C_HDR_CLR=1;
  - default width constant C_N_BIT=8 (shared with the ALU).
- Single flat module; no sub-module needed.
- The bench instantiates alu_driver together with the ALU, configured as a G_N_BIT adder (i_res = o_s1+o_s2 mod 2^G_N_BIT).

Test Plan:
- Reset, then frame 00,05,03 with i_res_ready=1: o_s1=05, o_s2=03; o_res=08 with o_res_valid high exactly 2 cycles after B is accepted; o_busy low afterwards.
- After the previous frame, CHAIN frame 01,10: o_s1=08, o_res=18. Then 00,FF,02: o_res=01 (wrap); accumulator is 01.
- i_res_ready low for 6 cycles while i_byte_valid=1 with a header pending: o_res stable, o_byte_ready=0 throughout; the header is accepted the cycle after S_HDR is re-entered.
- Frame 02 (CLR), then 01,07: o_s1=00, o_res=07, and no result is emitted for the CLR frame. Also header 03: treated as CLR only.
- Assert i_rst during S_B after 00,AA: no o_res_valid pulse. Then 01,01 yields o_res=01 (accumulator cleared). o_s1, o_s2 and o_res read 0 during and immediately after reset.
- Random bubbles inserted on i_byte_valid across 50 random frames: every o_res matches the adder model; no byte is lost or double-accepted.

Source files
------------

// File: rtl/alu_driver_pkg.sv
// Shared definitions for the ALU operand/result driver.
// Frame header bit positions, FSM states and default datapath width.
package alu_driver_pkg;

    localparam int C_N_BIT     = 8;
    localparam int C_HDR_CHAIN = 0;
    localparam int C_HDR_CLR   = 1;

    typedef enum logic [2:0] {
        S_HDR,
        S_A,
        S_B,
        S_EXEC,
        S_OUT
    } state_e;

endpackage

// File: rtl/alu_driver.sv
// Initiator side of the ALU operand/result interface: takes byte frames,
// drives registered operands, samples the ALU result and holds it for a consumer.
module alu_driver
    import alu_driver_pkg::*;
#(
    parameter int G_N_BIT = C_N_BIT
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [7:0]         i_byte,
    input  logic               i_byte_valid,
    output logic               o_byte_ready,
    output logic [G_N_BIT-1:0] o_s1,
    output logic [G_N_BIT-1:0] o_s2,
    input  logic [G_N_BIT-1:0] i_res,
    output logic [G_N_BIT-1:0] o_res,
    output logic               o_res_valid,
    input  logic               i_res_ready,
    output logic               o_busy
);

    state_e             state_q, state_d;
    logic [G_N_BIT-1:0] s1_q, s1_d;
    logic [G_N_BIT-1:0] s2_q, s2_d;
    logic [G_N_BIT-1:0] res_q, res_d;
    logic [G_N_BIT-1:0] acc_q, acc_d;
    logic               byte_ready;
    logic               xfer;

    assign byte_ready = (state_q == S_HDR) ||
                        (state_q == S_A)   ||
                        (state_q == S_B);
    assign xfer = i_byte_valid && byte_ready;

    always_comb begin
        state_d = state_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        res_d   = res_q;
        acc_d   = acc_q;
        unique case (state_q)
            S_HDR: begin
                // CLR wins over CHAIN and closes the frame immediately
                if (xfer) begin
                    if (i_byte[C_HDR_CLR]) begin
                        acc_d = '0;
                    end else if (i_byte[C_HDR_CHAIN]) begin
                        s1_d    = acc_q;
                        state_d = S_B;
                    end else begin
                        state_d = S_A;
                    end
                end
            end
            S_A: begin
                if (xfer) begin
                    s1_d    = i_byte[G_N_BIT-1:0];
                    state_d = S_B;
                end
            end
            S_B: begin
                if (xfer) begin
                    s2_d    = i_byte[G_N_BIT-1:0];
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                res_d   = i_res;
                acc_d   = i_res;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (i_res_ready) begin
                    state_d = S_HDR;
                end
            end
            default: begin
                state_d = S_HDR;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_HDR;
            s1_q    <= '0;
            s2_q    <= '0;
            res_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            res_q   <= res_d;
            acc_q   <= acc_d;
        end
    end

    assign o_byte_ready = byte_ready;
    assign o_s1         = s1_q;
    assign o_s2         = s2_q;
    assign o_res        = res_q;
    assign o_res_valid  = (state_q == S_OUT);
    assign o_busy       = (state_q != S_HDR);

endmodule

// File: tb/tb_alu_driver.sv
// Scoreboard bench for alu_driver paired with an 8-bit adder ALU.
// Stimulus pushes expected results; a monitor pops on each result handshake.
module tb_alu_driver;

    localparam int NB = 8;

    logic          clk;
    logic          i_rst;
    logic [7:0]    i_byte;
    logic          i_byte_valid;
    logic          o_byte_ready;
    logic [NB-1:0] o_s1;
    logic [NB-1:0] o_s2;
    logic [NB-1:0] i_res;
    logic [NB-1:0] o_res;
    logic          o_res_valid;
    logic          i_res_ready;
    logic          o_busy;

    int            total;
    int            bad;
    int            pushed;
    int            popped;
    logic [7:0]    exp_q[$];
    logic [7:0]    acc_m;
    logic          rnd_rdy;

    alu_driver #(.G_N_BIT(NB)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_byte      (i_byte),
        .i_byte_valid(i_byte_valid),
        .o_byte_ready(o_byte_ready),
        .o_s1        (o_s1),
        .o_s2        (o_s2),
        .i_res       (i_res),
        .o_res       (o_res),
        .o_res_valid (o_res_valid),
        .i_res_ready (i_res_ready),
        .o_busy      (o_busy)
    );

    assign i_res = o_s1 + o_s2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Handshake sampled just after the negedge, once inputs are settled
    always begin
        @(negedge clk);
        #1;
        if (o_res_valid && i_res_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_res", {24'h0, o_res}, 32'hffff_ffff);
            end else begin
                chk("res", {24'h0, o_res}, {24'h0, exp_q.pop_front()});
                popped++;
            end
        end
    end

    always @(negedge clk) begin
        if (rnd_rdy) i_res_ready = 1'($urandom_range(0, 1));
    end

    task automatic send(input logic [7:0] b, input int bubbles);
        int n;
        i_byte_valid = 1'b0;
        repeat (bubbles) tick();
        i_byte       = b;
        i_byte_valid = 1'b1;
        n = 0;
        while (!o_byte_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) chk("send_timeout", n, 0);
        tick();
        i_byte_valid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] h, input logic [7:0] a,
                         input logic [7:0] b, input int bub);
        logic [7:0] s1;
        if (h[1]) begin
            acc_m = 8'h00;
            send(h, bub);
            return;
        end
        s1 = h[0] ? acc_m : a;
        acc_m = s1 + b;
        send(h, bub);
        if (!h[0]) send(a, bub);
        exp_q.push_back(acc_m);
        pushed++;
        send(b, bub);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        chk(name, exp_q.size(), 0);
        tick();
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        pushed       = 0;
        popped       = 0;
        acc_m        = 8'h00;
        rnd_rdy      = 1'b0;
        i_rst        = 1'b1;
        i_byte       = 8'h00;
        i_byte_valid = 1'b0;
        i_res_ready  = 1'b0;
        tick();
        tick();
        chk("rst_s1", o_s1, 0);
        chk("rst_s2", o_s2, 0);
        chk("rst_res", o_res, 0);
        chk("rst_valid", o_res_valid, 0);
        chk("rst_busy", o_busy, 0);
        i_rst       = 1'b0;
        i_res_ready = 1'b1;
        tick();

        // Basic frame with exact latency
        send(8'h00, 0);
        send(8'h05, 0);
        acc_m = 8'h08;
        exp_q.push_back(8'h08);
        pushed++;
        send(8'h03, 0);
        chk("f1_s1", o_s1, 8'h05);
        chk("f1_s2", o_s2, 8'h03);
        chk("f1_exec_valid", o_res_valid, 0);
        tick();
        chk("f1_out_valid", o_res_valid, 1);
        chk("f1_out_res", o_res, 8'h08);
        tick();
        chk("f1_idle_busy", o_busy, 0);
        chk("f1_idle_valid", o_res_valid, 0);

        // Chain and wrap
        frame(8'h01, 8'h00, 8'h10, 0);
        chk("chain_s1", o_s1, 8'h08);
        drain("chain_drain");
        frame(8'h00, 8'hFF, 8'h02, 0);
        drain("wrap_drain");
        frame(8'h01, 8'h00, 8'h00, 0);
        chk("acc01_s1", o_s1, 8'h01);
        drain("acc01_drain");

        // Output stall with a header held off
        i_res_ready = 1'b0;
        frame(8'h00, 8'h01, 8'h02, 0);
        i_byte       = 8'h00;
        i_byte_valid = 1'b1;
        tick();
        chk("stall_valid0", o_res_valid, 1);
        for (int i = 0; i < 6; i++) begin
            chk("stall_res", o_res, 8'h03);
            chk("stall_ready", o_byte_ready, 0);
            chk("stall_vld", o_res_valid, 1);
            tick();
        end
        i_res_ready = 1'b1;
        tick();
        chk("rel_ready", o_byte_ready, 1);
        chk("rel_busy", o_busy, 0);
        tick();
        chk("hdr_taken", o_busy, 1);
        i_byte_valid = 1'b0;
        acc_m = 8'h09;
        exp_q.push_back(8'h09);
        pushed++;
        send(8'h04, 0);
        send(8'h05, 0);
        drain("stall_drain");

        // CLR, then CLR+CHAIN header
        frame(8'h02, 8'h00, 8'h00, 0);
        chk("clr_busy", o_busy, 0);
        chk("clr_valid", o_res_valid, 0);
        frame(8'h01, 8'h00, 8'h07, 0);
        chk("clr_chain_s1", o_s1, 8'h00);
        drain("clr_drain");
        frame(8'h03, 8'h00, 8'h00, 0);
        chk("clr3_busy", o_busy, 0);
        frame(8'h01, 8'h00, 8'h04, 0);
        chk("clr3_s1", o_s1, 8'h00);
        drain("clr3_drain");

        // Reset mid-frame
        send(8'h00, 0);
        send(8'hAA, 0);
        i_rst = 1'b1;
        tick();
        chk("mrst_s1", o_s1, 0);
        chk("mrst_s2", o_s2, 0);
        chk("mrst_res", o_res, 0);
        chk("mrst_valid", o_res_valid, 0);
        i_rst = 1'b0;
        tick();
        chk("mrst_s1_after", o_s1, 0);
        chk("mrst_res_after", o_res, 0);
        chk("mrst_busy_after", o_busy, 0);
        acc_m = 8'h00;
        frame(8'h01, 8'h00, 8'h01, 0);
        drain("mrst_drain");

        // Random frames with bubbles and back-pressure
        rnd_rdy = 1'b1;
        for (int k = 0; k < 50; k++) begin
            logic [7:0] h;
            h = ($urandom_range(0, 9) == 0) ? 8'h02 :
                8'(($urandom_range(0, 63) << 2) | $urandom_range(0, 1));
            frame(h, 8'($urandom), 8'($urandom), $urandom_range(0, 2));
        end
        rnd_rdy = 1'b0;
        tick();
        i_res_ready = 1'b1;
        drain("rand_drain");
        chk("count", popped, pushed);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
